// File: rtl/pubkey_serializer_if.sv
// Key-in / byte-out bus of the SEC1 public-key serializer.
// The slave side belongs to the serializer; the master side belongs to whatever drives it.
interface pubkey_serializer_if #(
    parameter int X_W = 256
);
    logic           in_valid;
    logic           in_ready;
    logic [X_W-1:0] pub_x;
    logic [X_W-1:0] pub_y;
    logic           compressed;
    logic [7:0]     out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic [6:0]     out_len;
    logic           err;
    logic           busy;

    modport slave (
        input  in_valid, pub_x, pub_y, compressed, out_ready,
        output in_ready, out_data, out_valid, out_last, out_len, err, busy
    );

    modport master (
        output in_valid, pub_x, pub_y, compressed, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_len, err, busy
    );
endinterface

// File: rtl/pubkey_serializer.sv
// Serializes an affine secp256k1 public key into its SEC1 byte encoding:
// 33 bytes when compressed, 65 bytes when uncompressed, over a valid/ready stream.
module pubkey_serializer #(
    parameter int X_W = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    pubkey_serializer_if.slave   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREFIX = 3'd1;
    localparam logic [2:0] S_XBYTES = 3'd2;
    localparam logic [2:0] S_YBYTES = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [6:0]       idx_q, idx_d;
    logic [2*X_W-1:0] sh_q, sh_d;    // {x, y}; the byte on the wire is always the top byte
    logic             comp_q, comp_d;
    logic             par_q, par_d;

    logic       streaming;
    logic       hs;
    logic [6:0] last_idx;

    assign streaming = (state_q == S_PREFIX) || (state_q == S_XBYTES) || (state_q == S_YBYTES);
    assign hs        = streaming && bus.out_ready;
    assign last_idx  = comp_q ? 7'd32 : 7'd64;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        comp_d  = comp_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sh_d    = {bus.pub_x, bus.pub_y};
                    comp_d  = bus.compressed;
                    par_d   = bus.pub_y[0];
                    idx_d   = 7'd0;
                    // Zero test on the very values being captured; no later input is looked at.
                    state_d = ((bus.pub_x == '0) && (bus.pub_y == '0)) ? S_ERR : S_PREFIX;
                end
            end
            S_ERR: state_d = S_IDLE;
            S_PREFIX: begin
                if (hs) begin
                    idx_d   = 7'd1;
                    state_d = S_XBYTES;
                end
            end
            S_XBYTES, S_YBYTES: begin
                if (hs) begin
                    sh_d = sh_q << 8;
                    if (idx_q == last_idx) begin
                        idx_d   = 7'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 7'd1;
                        if (idx_q == 7'd32) state_d = S_YBYTES;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 7'd0;
            sh_q    <= '0;
            comp_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            comp_q  <= comp_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        bus.out_data = 8'h00;
        if (state_q == S_PREFIX)
            bus.out_data = comp_q ? {7'b0000_001, par_q} : 8'h04;
        else if ((state_q == S_XBYTES) || (state_q == S_YBYTES))
            bus.out_data = sh_q[2*X_W-1 -: 8];
    end

    assign bus.out_valid = streaming;
    assign bus.out_last  = streaming && (idx_q == last_idx);
    assign bus.out_len   = streaming ? (comp_q ? 7'd33 : 7'd65) : 7'd0;
    assign bus.err       = (state_q == S_ERR);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.in_ready  = (state_q == S_IDLE);
endmodule

// File: tb/tb_pubkey_serializer.sv
// Scoreboard bench for pubkey_serializer: expected bytes are queued at accept and
// popped on each handshake; stalls, zero keys, ignored inputs and mid-frame reset are exercised.
module tb_pubkey_serializer;
    localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pubkey_serializer_if #(.X_W(256)) bus ();
    pubkey_serializer #(.X_W(256)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         n_cmp = 0;
    int         n_err = 0;
    int         hs_cnt = 0;
    logic [8:0] sb[$];          // {last, data}
    logic [6:0] exp_len = 7'd0;
    logic       bp_en = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = 9'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Monitor: sample at the falling edge; a beat seen here with ready high is taken at the next rise.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_beat", {bus.out_last, bus.out_data}, prev_beat);
            end
            if (bus.out_valid) chk("out_len", bus.out_len, exp_len);
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) chk("beat", {bus.out_last, bus.out_data}, sb.pop_front());
                hs_cnt++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_beat  = {bus.out_last, bus.out_data};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_last"}, bus.out_last, 0);
        chk({tag, "_data"}, bus.out_data, 0);
        chk({tag, "_len"}, bus.out_len, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    // Presents one key for exactly one accept edge and queues its expected encoding.
    task automatic send_key(input logic [255:0] x, input logic [255:0] y, input logic c);
        int t = 0;
        while (!bus.in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        bus.in_valid   = 1'b1;
        bus.pub_x      = x;
        bus.pub_y      = y;
        bus.compressed = c;
        if (!(x == '0 && y == '0)) begin
            exp_len = c ? 7'd33 : 7'd65;
            sb.push_back({1'b0, c ? {7'b0000_001, y[0]} : 8'h04});
            for (int i = 31; i >= 0; i--) sb.push_back({c && (i == 0), x[i*8 +: 8]});
            if (!c) for (int i = 31; i >= 0; i--) sb.push_back({i == 0, y[i*8 +: 8]});
        end
        hs_cnt = 0;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.pub_x      = '1;
        bus.pub_y      = '1;
        bus.compressed = ~c;
    endtask

    task automatic wait_frame(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(posedge clk); #1; t++;
        end
        chk({tag, "_drained"}, sb.size(), 0);
        chk({tag, "_valid_after"}, bus.out_valid, 0);
        chk({tag, "_last_after"}, bus.out_last, 0);
        chk({tag, "_in_ready_after"}, bus.in_ready, 1);
        chk({tag, "_len_after"}, bus.out_len, 0);
        chk({tag, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.pub_x      = '0;
        bus.pub_y      = '0;
        bus.compressed = 1'b0;
        bus.out_ready  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        send_key(GX, GY, 1'b1);
        chk("g_c_latency", bus.out_valid, 1);
        chk("g_c_prefix", bus.out_data, 8'h02);
        wait_frame("g_c");
        chk("g_c_hs", hs_cnt, 33);

        send_key(GX, GY, 1'b0);
        chk("g_u_prefix", bus.out_data, 8'h04);
        wait_frame("g_u");
        chk("g_u_hs", hs_cnt, 65);

        send_key(256'd1, 256'd3, 1'b1);
        chk("odd_prefix", bus.out_data, 8'h03);
        wait_frame("odd");

        bp_en = 1'b1;
        send_key(GX, GY, 1'b0);
        wait_frame("bp");
        chk("bp_hs", hs_cnt, 65);
        bp_en = 1'b0;

        send_key('0, '0, 1'b1);
        chk("zero_err", bus.err, 1);
        chk("zero_valid", bus.out_valid, 0);
        chk("zero_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        chk("zero_err_pulse", bus.err, 0);
        chk("zero_in_ready2", bus.in_ready, 1);
        chk("zero_valid2", bus.out_valid, 0);

        send_key(GX, GY, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_in_ready", bus.in_ready, 0);
        chk("busy_flag", bus.busy, 1);
        bus.in_valid   = 1'b1;
        bus.pub_x      = 256'd1;
        bus.pub_y      = 256'd3;
        bus.compressed = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_frame("busy_in");
        chk("busy_in_hs", hs_cnt, 33);

        begin
            int t = 0;
            send_key(GX, GY, 1'b0);
            while (hs_cnt < 10 && t < 500) begin
                @(posedge clk); #1; t++;
            end
            chk("mid_reach10", hs_cnt, 10);
            rst = 1'b1;
            sb.delete();
            @(posedge clk); #1;
            check_idle("mid_rst");
            rst = 1'b0;
        end
        send_key(GX, GY, 1'b1);
        chk("post_rst_prefix", bus.out_data, 8'h02);
        wait_frame("post_rst");
        chk("post_rst_hs", hs_cnt, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
